axis_pkt_rx: RTL and testbench
==============================

Name: axis_pkt_rx

Overview:
Parametrised AXI-Stream packet receiver, next generation of the single-word stream slave. Once armed by the user app it accepts one full packet (beats through tlast) into an internal DEPTH-word buffer. It then raises finish and exposes the packet length, an overflow flag and a registered random-access read port. It sits between an AXI-Stream master and user logic that consumes whole packets.

Parameters:
DATA_W, 32, width of tdata, the buffer words and rd_data.
DEPTH, 16, buffer capacity in beats; power of 2, minimum 2.
AW (localparam), $clog2(DEPTH), read address width.
LW (localparam), $clog2(DEPTH)+1, packet length width; holds 0..DEPTH.

Ports:
aclk  in  1  clock; all logic on the rising edge.
areset_n  in  1  reset, synchronous, active-low.
ready  in  1  user arm/acknowledge; high = app ready to take a new packet.
tready  out  1  AXI-S ready, registered.
tvalid  in  1  AXI-S valid.
tlast  in  1  AXI-S last beat of the packet.
tdata  in  DATA_W  AXI-S data.
rd_addr  in  AW  buffer read address.
rd_data  out  DATA_W  buffer word at rd_addr, registered.
pkt_len  out  LW  stored beat count of the last packet, saturates at DEPTH.
overflow  out  1  last packet exceeded DEPTH beats; excess beats dropped.
finish  out  1  packet complete and held in the buffer.

Behaviour:
- Reset (areset_n=0 at an edge): state IDLE; tready=0, finish=0, overflow=0, pkt_len=0, rd_data=0, beat counter=0. Buffer RAM is not reset. Reset mid-packet abandons the packet; the remaining beats are not accepted because tready=0.
- Handshake: hs = tvalid & tready. tdata and tlast are ignored when hs=0.
- FSM states: IDLE, RECV, DONE.
- IDLE: tready=0.
  - ready=1 at an edge -> RECV; tready=1, count=0, overflow=0, finish=0 after that edge.
- RECV: tready=1; one beat accepted per cycle, with no bubbles on back-to-back beats.
  - hs with count<DEPTH: buf[count]<=tdata, count<=count+1.
  - hs with count==DEPTH: beat discarded, overflow<=1, count holds.
  - hs with tlast=1: -> DONE. The write or discard above still applies to this beat. tready<=0, finish<=1, pkt_len<=min(count+1, DEPTH) after that edge.
  - ready deasserting in RECV has no effect: the packet is always received to tlast once armed.
- DONE: tready=0, finish=1; pkt_len and overflow hold.
  - ready=1 at an edge (acknowledge) -> RECV directly: finish<=0, overflow<=0, count<=0, tready<=1. pkt_len holds until the next tlast.
  - A user holding ready permanently high gets continuous packet reception, with one tready-low cycle after each tlast.
- Read port: every edge rd_data<=buf[rd_addr], 1-cycle latency in all states. Contents are guaranteed only in DONE for addresses < pkt_len. Reads in RECV may return stale or new data; a same-edge write/read to one address returns the old word.
- Latency: tready rises 1 cycle after ready is sampled in IDLE/DONE. finish rises the edge after the tlast handshake.
- Width rules: count and pkt_len are LW bits and never wrap; the count==DEPTH saturation above governs.
- Simultaneous events: in DONE, ready=1 and tvalid=1 in the same cycle accepts no beat that cycle (tready=0). Reset overrides everything.

Test Plan:
1. Reset, then ready=1 for 1 cycle -> tready=1 on the next cycle and stays 1 after ready drops. Send 1 beat 0xDEADBEEF with tlast -> finish=1, pkt_len=1, overflow=0, tready=0. rd_addr=0 -> rd_data=0xDEADBEEF one cycle later.
2. Armed, send 16 back-to-back beats 0x100..0x10F, tlast on the 16th -> pkt_len=16, overflow=0. Reading addresses 0..15 returns 0x100..0x10F.
3. Armed, send 18 beats 0x200..0x211, tlast on the 18th -> all 18 handshakes complete; pkt_len=16, overflow=1; addr 15 reads 0x20F.
4. Master inserts tvalid gaps (beat, 2 idle cycles, beat+tlast); tlast asserted on an idle tvalid=0 cycle -> ignored. Only 2 beats stored, pkt_len=2.
5. ready held high throughout, two 3-beat packets back-to-back -> finish pulses for 1 cycle per packet. tready is low for exactly 1 cycle between packets; pkt_len=3 both times; data of packet 2 overwrites addresses 0..2.
6. areset_n=0 after beat 2 of a 5-beat packet -> tready=0, finish=0, pkt_len=0, overflow=0 next cycle. Remaining beats stall; re-arm then a new 1-beat packet gives pkt_len=1.

Source files
------------

// File: rtl/axis_pkt_rx.sv
// axis_pkt_rx: AXI-Stream packet receiver. Once armed it captures one packet
// (through tlast) into a DEPTH-word buffer, then reports length/overflow and
// serves the stored words through a registered random-access read port.
module axis_pkt_rx #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    input  logic                      ready,
    output logic                      tready,
    input  logic                      tvalid,
    input  logic                      tlast,
    input  logic [DATA_W-1:0]         tdata,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]    pkt_len,
    output logic                      overflow,
    output logic                      finish
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            tready_q, tready_d;
    logic            finish_q, finish_d;
    logic            overflow_q, overflow_d;
    logic [LW-1:0]   count_q, count_d;
    logic [LW-1:0]   pkt_len_q, pkt_len_d;
    logic [DATA_W-1:0] rd_data_q;
    logic            hs_c;
    logic            buf_full_c;
    logic            wr_en_c;

    logic [DATA_W-1:0] mem [DEPTH];

    assign hs_c       = tvalid & tready_q;
    assign buf_full_c = (count_q == LW'(DEPTH));
    assign wr_en_c    = (state_q == RECV) & hs_c & ~buf_full_c;

    // Control state and status registers; synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q    <= IDLE;
            tready_q   <= 1'b0;
            finish_q   <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            pkt_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            tready_q   <= tready_d;
            finish_q   <= finish_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            pkt_len_q  <= pkt_len_d;
        end
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d    = state_q;
        tready_d   = tready_q;
        finish_d   = finish_q;
        overflow_d = overflow_q;
        count_d    = count_q;
        pkt_len_d  = pkt_len_q;

        case (state_q)
            IDLE: begin
                tready_d = 1'b0;
                if (ready) begin
                    state_d    = RECV;
                    tready_d   = 1'b1;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    finish_d   = 1'b0;
                end
            end
            RECV: begin
                if (hs_c) begin
                    // Beats beyond DEPTH are dropped but still handshaken.
                    if (buf_full_c) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + LW'(1);
                    end
                    if (tlast) begin
                        state_d   = DONE;
                        tready_d  = 1'b0;
                        finish_d  = 1'b1;
                        pkt_len_d = buf_full_c ? LW'(DEPTH) : (count_q + LW'(1));
                    end
                end
            end
            DONE: begin
                tready_d = 1'b0;
                if (ready) begin
                    state_d    = RECV;
                    tready_d   = 1'b1;
                    finish_d   = 1'b0;
                    overflow_d = 1'b0;
                    count_d    = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                tready_d = 1'b0;
            end
        endcase
    end

    // Packet buffer write; storage is intentionally not reset.
    always_ff @(posedge aclk) begin
        if (wr_en_c) begin
            mem[count_q[AW-1:0]] <= tdata;
        end
    end

    // Registered read port; a same-edge write to rd_addr returns the old word.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign tready   = tready_q;
    assign finish   = finish_q;
    assign overflow = overflow_q;
    assign pkt_len  = pkt_len_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_axis_pkt_rx.sv
// Directed bench for axis_pkt_rx with a data scoreboard: accepted beats are
// queued as they are driven and compared against read-port output later.
module tb_axis_pkt_rx;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned LW     = $clog2(DEPTH) + 1;

    logic              aclk = 1'b0;
    logic              areset_n;
    logic              ready;
    logic              tready;
    logic              tvalid;
    logic              tlast;
    logic [DATA_W-1:0] tdata;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [LW-1:0]     pkt_len;
    logic              overflow;
    logic              finish;

    int checks = 0;
    int errors = 0;
    int stored = 0;
    logic [DATA_W-1:0] exp_q[$];

    axis_pkt_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .ready    (ready),
        .tready   (tready),
        .tvalid   (tvalid),
        .tlast    (tlast),
        .tdata    (tdata),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .pkt_len  (pkt_len),
        .overflow (overflow),
        .finish   (finish)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one beat and hold it until it is handshaken (bounded wait).
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
        int guard;
        guard  = 0;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        while (tready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("beat_tready", 64'(tready), 64'(1));
        if (stored < int'(DEPTH)) begin
            exp_q.push_back(d);
            stored++;
        end
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [DATA_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            send_beat(base + DATA_W'(i), (i == n - 1));
        end
    endtask

    task automatic new_pkt();
        exp_q.delete();
        stored = 0;
    endtask

    task automatic arm();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("arm_tready", 64'(tready), 64'(1));
    endtask

    task automatic check_done(input int beats);
        int len;
        len = (beats > int'(DEPTH)) ? int'(DEPTH) : beats;
        check("done_finish",   64'(finish),   64'(1));
        check("done_tready",   64'(tready),   64'(0));
        check("done_pkt_len",  64'(pkt_len),  64'(len));
        check("done_overflow", 64'(overflow), 64'(beats > int'(DEPTH)));
    endtask

    task automatic read_back(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = AW'(i);
            tick();
            check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
        end
    endtask

    initial begin
        areset_n = 1'b0;
        ready    = 1'b0;
        tvalid   = 1'b0;
        tlast    = 1'b0;
        tdata    = '0;
        rd_addr  = '0;
        tick();
        tick();
        check("rst_tready",   64'(tready),   64'(0));
        check("rst_finish",   64'(finish),   64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_pkt_len",  64'(pkt_len),  64'(0));
        check("rst_rd_data",  64'(rd_data),  64'(0));
        areset_n = 1'b1;
        tick();
        check("idle_tready", 64'(tready), 64'(0));

        // 1: single-beat packet
        arm();
        tick();
        check("armed_hold_tready", 64'(tready), 64'(1));
        new_pkt();
        send_pkt(1, 32'hDEAD_BEEF);
        check_done(1);
        read_back(1);

        // 2: exactly DEPTH beats back to back
        arm();
        new_pkt();
        send_pkt(16, 32'h100);
        check_done(16);
        read_back(16);

        // 3: overflow, 18 beats, last two dropped
        arm();
        new_pkt();
        send_pkt(18, 32'h200);
        check_done(18);
        read_back(16);

        // 4: tvalid gaps; tlast on an idle cycle is ignored
        arm();
        new_pkt();
        send_beat(32'h300, 1'b0);
        tlast = 1'b1;
        tick();
        tlast = 1'b0;
        tick();
        check("gap_finish", 64'(finish), 64'(0));
        check("gap_tready", 64'(tready), 64'(1));
        send_beat(32'h301, 1'b1);
        check_done(2);
        read_back(2);

        // 5: ready held high, two 3-beat packets back to back
        ready = 1'b1;
        tick();
        check("cont_tready", 64'(tready), 64'(1));
        new_pkt();
        send_pkt(3, 32'h400);
        check_done(3);
        // tvalid high during the DONE cycle must not be accepted
        tvalid = 1'b1;
        tdata  = 32'h500;
        tlast  = 1'b0;
        tick();
        check("cont_finish_pulse", 64'(finish), 64'(0));
        check("cont_tready_gap",   64'(tready), 64'(1));
        new_pkt();
        send_beat(32'h500, 1'b0);
        send_beat(32'h501, 1'b0);
        send_beat(32'h502, 1'b1);
        ready = 1'b0;
        check_done(3);
        read_back(3);

        // 6: reset in the middle of a packet
        arm();
        new_pkt();
        send_beat(32'h600, 1'b0);
        send_beat(32'h601, 1'b0);
        areset_n = 1'b0;
        tvalid   = 1'b1;
        tdata    = 32'h602;
        tick();
        areset_n = 1'b1;
        check("mid_rst_tready",   64'(tready),   64'(0));
        check("mid_rst_finish",   64'(finish),   64'(0));
        check("mid_rst_pkt_len",  64'(pkt_len),  64'(0));
        check("mid_rst_overflow", 64'(overflow), 64'(0));
        tick();
        tick();
        check("stall_tready", 64'(tready), 64'(0));
        check("stall_finish", 64'(finish), 64'(0));
        tvalid = 1'b0;
        arm();
        new_pkt();
        send_pkt(1, 32'h700);
        check_done(1);
        read_back(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
